// File: rtl/ps2_pkg.sv
// Shared definitions for the PS/2 keyboard receiver: the frame FSM encoding,
// the data width and the default inactivity timeout.
package ps2_pkg;

  localparam int DATA_BITS              = 8;
  localparam int BIT_CNT_W              = $clog2(DATA_BITS);
  localparam int DEFAULT_TIMEOUT_CYCLES = 100000;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DATA   = 2'd1,
    ST_PARITY = 2'd2,
    ST_STOP   = 2'd3
  } ps2_state_e;

  // PS/2 uses odd parity: data bits plus the parity bit hold an odd number of ones.
  function automatic logic odd_parity_ok(input logic [DATA_BITS-1:0] data,
                                         input logic                 parity);
    return ^{data, parity};
  endfunction

endpackage

// File: rtl/ps2_glitch_filter.sv
// Synchronizes the PS/2 clock and data lines, debounces the clock and emits a
// one-cycle pulse on each filtered clock falling edge.
module ps2_glitch_filter #(
  parameter int FILTER_LEN = 4
) (
  input  logic clk,
  input  logic reset_n,
  input  logic kb_clk_i,
  input  logic kb_data_i,
  output logic data_sync_o,
  output logic fall_o
);

  localparam int CNT_W = $clog2(FILTER_LEN + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FILTER_LEN - 1);

  logic [1:0]       clk_sync_q;
  logic [1:0]       data_sync_q;
  logic             filt_q, filt_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Count consecutive synchronized samples that disagree with the filtered
  // value; the filtered clock flips on the FILTER_LEN-th one.
  // NOTE: every signal driven here gets a default first so no latch is inferred.
  always_comb begin
    filt_d = filt_q;
    cnt_d  = '0;
    if (clk_sync_q[1] != filt_q) begin
      if (cnt_q == CNT_LAST) begin
        filt_d = clk_sync_q[1];
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments only.
  // Reset values mirror an idle PS/2 bus, where both lines are pulled high.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      clk_sync_q  <= 2'b11;
      data_sync_q <= 2'b11;
      filt_q      <= 1'b1;
      cnt_q       <= '0;
    end else begin
      clk_sync_q  <= {clk_sync_q[0], kb_clk_i};
      data_sync_q <= {data_sync_q[0], kb_data_i};
      filt_q      <= filt_d;
      cnt_q       <= cnt_d;
    end
  end

  assign fall_o      = filt_q & ~filt_d;
  assign data_sync_o = data_sync_q[1];

endmodule

// File: rtl/ps2_receiver.sv
// PS/2 keyboard frame receiver: start, 8 data bits LSB first, odd parity and
// stop; reports good bytes, parity errors and framing/timeout errors.
module ps2_receiver
  import ps2_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES,
  parameter int FILTER_LEN     = 4
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 kb_clk,
  input  logic                 kb_data,
  output logic [DATA_BITS-1:0] scan_code,
  output logic                 valid_scan_code,
  output logic                 parity_err,
  output logic                 frame_err
);

  localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);
  localparam logic [BIT_CNT_W-1:0] BIT_LAST = BIT_CNT_W'(DATA_BITS - 1);

  logic                 sample;
  logic                 data_bit;
  logic                 timeout;

  ps2_state_e           state_q, state_d;
  logic [BIT_CNT_W-1:0] bit_cnt_q, bit_cnt_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 parity_q, parity_d;
  logic [TMO_W-1:0]     tmo_q, tmo_d;
  logic [DATA_BITS-1:0] scan_q, scan_d;
  logic                 valid_q, valid_d;
  logic                 perr_q, perr_d;
  logic                 ferr_q, ferr_d;

  ps2_glitch_filter #(
    .FILTER_LEN (FILTER_LEN)
  ) u_filter (
    .clk         (clk),
    .reset_n     (reset_n),
    .kb_clk_i    (kb_clk),
    .kb_data_i   (kb_data),
    .data_sync_o (data_bit),
    .fall_o      (sample)
  );

  assign timeout = (state_q != ST_IDLE) && (tmo_q >= TMO_LAST);

  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    parity_d  = parity_q;
    scan_d    = scan_q;
    valid_d   = 1'b0;
    perr_d    = 1'b0;
    ferr_d    = 1'b0;

    // Inactivity counter saturates so a stalled keyboard cannot wrap it.
    if (state_q == ST_IDLE || sample) begin
      tmo_d = '0;
    end else if (tmo_q < TMO_LAST) begin
      tmo_d = tmo_q + 1'b1;
    end else begin
      tmo_d = tmo_q;
    end

    case (state_q)
      ST_IDLE: begin
        if (sample && !data_bit) begin
          state_d   = ST_DATA;
          bit_cnt_d = '0;
          shift_d   = '0;
        end
      end
      ST_DATA: begin
        if (sample) begin
          shift_d   = {data_bit, shift_q[DATA_BITS-1:1]};
          bit_cnt_d = bit_cnt_q + 1'b1;
          if (bit_cnt_q == BIT_LAST) begin
            state_d = ST_PARITY;
          end
        end
      end
      ST_PARITY: begin
        if (sample) begin
          parity_d = data_bit;
          state_d  = ST_STOP;
        end
      end
      ST_STOP: begin
        if (sample) begin
          state_d   = ST_IDLE;
          bit_cnt_d = '0;
          // A bad stop bit outranks a parity failure.
          if (!data_bit) begin
            ferr_d = 1'b1;
          end else if (odd_parity_ok(shift_q, parity_q)) begin
            scan_d  = shift_q;
            valid_d = 1'b1;
          end else begin
            perr_d = 1'b1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // A sample event in the same cycle keeps the frame alive.
    if (timeout && !sample) begin
      state_d   = ST_IDLE;
      bit_cnt_d = '0;
      shift_d   = '0;
      valid_d   = 1'b0;
      perr_d    = 1'b0;
      ferr_d    = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= ST_IDLE;
      bit_cnt_q <= '0;
      shift_q   <= '0;
      parity_q  <= 1'b0;
      tmo_q     <= '0;
      scan_q    <= '0;
      valid_q   <= 1'b0;
      perr_q    <= 1'b0;
      ferr_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      shift_q   <= shift_d;
      parity_q  <= parity_d;
      tmo_q     <= tmo_d;
      scan_q    <= scan_d;
      valid_q   <= valid_d;
      perr_q    <= perr_d;
      ferr_q    <= ferr_d;
    end
  end

  assign scan_code       = scan_q;
  assign valid_scan_code = valid_q;
  assign parity_err      = perr_q;
  assign frame_err       = ferr_q;

endmodule

// File: tb/tb_ps2_receiver.sv
// Self-checking bench for ps2_receiver: frame-level event model, per-cycle
// output comparison, directed scenarios and randomized frames.
`timescale 1ns/1ps
module tb_ps2_receiver;

  localparam int T_CYC = 300;
  localparam int F_LEN = 4;
  localparam int HP    = 40;

  typedef enum int {EV_VALID = 0, EV_PERR = 1, EV_FERR = 2} ev_kind_e;
  typedef struct {
    ev_kind_e   kind;
    logic [7:0] data;
  } ev_t;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       kb_clk = 1'b1;
  logic       kb_data = 1'b1;
  logic [7:0] scan_code;
  logic       valid_scan_code;
  logic       parity_err;
  logic       frame_err;

  int checks = 0;
  int errors = 0;

  ev_t        exp_q[$];
  logic [7:0] exp_scan = 8'h00;
  logic [7:0] valid_log[$];
  int         n_valid = 0, n_perr = 0, n_ferr = 0;
  logic       prev_valid = 1'b0;

  ps2_receiver #(
    .TIMEOUT_CYCLES (T_CYC),
    .FILTER_LEN     (F_LEN)
  ) dut (
    .clk             (clk),
    .reset_n         (reset_n),
    .kb_clk          (kb_clk),
    .kb_data         (kb_data),
    .scan_code       (scan_code),
    .valid_scan_code (valid_scan_code),
    .parity_err      (parity_err),
    .frame_err       (frame_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  // Behavioural model: what a whole frame must produce.
  function automatic ev_t frame_event(input logic [7:0] d, input logic par, input logic stop);
    ev_t e;
    e.data = d;
    if (!stop)              e.kind = EV_FERR;
    else if (^{d, par})     e.kind = EV_VALID;
    else                    e.kind = EV_PERR;
    return e;
  endfunction

  // Compare process: every cycle, outputs against the model.
  always @(negedge clk) begin
    int       npulse;
    ev_kind_e kind;
    ev_t      e;
    if (!reset_n) begin
      check("reset_outputs", {scan_code, valid_scan_code, parity_err, frame_err}, 32'h0);
      prev_valid = 1'b0;
    end else begin
      npulse = int'(valid_scan_code) + int'(parity_err) + int'(frame_err);
      check("pulse_mutex", npulse <= 1, 1);
      if (npulse >= 1) begin
        kind = valid_scan_code ? EV_VALID : (parity_err ? EV_PERR : EV_FERR);
        check("event_expected", exp_q.size() > 0, 1);
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          check("event_kind", int'(kind), int'(e.kind));
          if (e.kind == EV_VALID) exp_scan = e.data;
        end
        if (valid_scan_code) begin
          n_valid++;
          valid_log.push_back(scan_code);
          check("valid_width", prev_valid, 0);
        end
        if (parity_err) n_perr++;
        if (frame_err)  n_ferr++;
      end
      check("scan_code", scan_code, exp_scan);
      prev_valid = valid_scan_code;
    end
  end

  task automatic wait_cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_bit(input logic b);
    kb_data = b;
    wait_cycles(HP / 2);
    kb_clk = 1'b0;
    wait_cycles(HP);
    kb_clk = 1'b1;
    wait_cycles(HP / 2);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic par, input logic stop);
    exp_q.push_back(frame_event(d, par, stop));
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(d[i]);
    send_bit(par);
    send_bit(stop);
    kb_data = 1'b1;
    wait_cycles(HP / 2);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int  v0, p0, f0, n, seen;
    logic [7:0] d;
    logic       par, stop;
    int         sel;

    wait_cycles(5);
    reset_n = 1'b1;
    wait_cycles(10);

    // Single good frame.
    v0 = n_valid; p0 = n_perr; f0 = n_ferr;
    send_frame(8'h1C, 1'b0, 1'b1);
    check("f1c_scan", scan_code, 32'h1C);
    check("f1c_valid_count", n_valid - v0, 1);
    check("f1c_no_errors", (n_perr - p0) + (n_ferr - f0), 0);

    // Back-to-back frames.
    v0 = n_valid;
    send_frame(8'h16, 1'b0, 1'b1);
    send_frame(8'hF0, 1'b1, 1'b1);
    send_frame(8'h16, 1'b0, 1'b1);
    check("b2b_count", n_valid - v0, 3);
    if (valid_log.size() >= 3) begin
      check("b2b_first",  valid_log[valid_log.size()-3], 32'h16);
      check("b2b_second", valid_log[valid_log.size()-2], 32'hF0);
      check("b2b_third",  valid_log[valid_log.size()-1], 32'h16);
    end

    // Good 0x1C then same byte with wrong parity.
    send_frame(8'h1C, 1'b0, 1'b1);
    v0 = n_valid; p0 = n_perr;
    send_frame(8'h1C, 1'b1, 1'b1);
    check("perr_count", n_perr - p0, 1);
    check("perr_no_valid", n_valid - v0, 0);
    check("perr_scan_held", scan_code, 32'h1C);

    // Bad stop bit with bad parity too: frame error only.
    p0 = n_perr; f0 = n_ferr;
    send_frame(8'h55, 1'b0, 1'b0);
    check("stop_ferr_count", n_ferr - f0, 1);
    check("stop_no_perr", n_perr - p0, 0);

    // Timeout after start plus four data bits.
    f0 = n_ferr;
    exp_q.push_back('{kind: EV_FERR, data: 8'h00});
    send_bit(1'b0);
    send_bit(1'b0);
    send_bit(1'b1);
    send_bit(1'b0);
    kb_data = 1'b1;
    wait_cycles(HP / 2);
    kb_clk = 1'b0;
    n = 0;
    seen = 0;
    while (!seen && n < 3 * T_CYC) begin
      @(negedge clk);
      n++;
      if (n == HP) kb_clk = 1'b1;
      if (frame_err) seen = 1;
    end
    kb_clk = 1'b1;
    check("timeout_seen", seen, 1);
    check("timeout_latency", (n >= T_CYC) && (n <= T_CYC + F_LEN + 8), 1);
    wait_cycles(HP);
    check("timeout_ferr_count", n_ferr - f0, 1);
    send_frame(8'h2A, 1'b0, 1'b1);
    check("after_timeout_scan", scan_code, 32'h2A);

    // Short clock glitch in IDLE with data low must not start a frame.
    kb_data = 1'b0;
    wait_cycles(5);
    kb_clk = 1'b0;
    wait_cycles(2);
    kb_clk = 1'b1;
    wait_cycles(20);
    kb_data = 1'b1;
    wait_cycles(HP);
    send_frame(8'h1C, 1'b0, 1'b1);
    check("after_glitch_scan", scan_code, 32'h1C);

    // Reset in the middle of a frame.
    send_bit(1'b0);
    send_bit(1'b1);
    send_bit(1'b1);
    exp_q.delete();
    exp_scan = 8'h00;
    reset_n  = 1'b0;
    wait_cycles(3);
    check("rst_scan",  scan_code, 32'h00);
    check("rst_pulses", {valid_scan_code, parity_err, frame_err}, 32'h0);
    reset_n = 1'b1;
    wait_cycles(HP);
    v0 = n_valid;
    send_frame(8'h1C, 1'b0, 1'b1);
    check("after_reset_valid", n_valid - v0, 1);
    check("after_reset_scan", scan_code, 32'h1C);

    // Randomized frames with occasional parity and stop faults.
    for (int k = 0; k < 24; k++) begin
      d    = 8'($urandom_range(0, 255));
      sel  = $urandom_range(0, 9);
      par  = ~(^d);
      stop = 1'b1;
      if (sel == 8) par  = ^d;
      if (sel == 9) stop = 1'b0;
      if (sel == 0) begin
        par  = $urandom_range(0, 1);
        stop = $urandom_range(0, 1);
      end
      send_frame(d, par, stop);
      wait_cycles($urandom_range(0, HP));
    end

    wait_cycles(50);
    check("events_drained", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
